// File: rtl/a0_uart_tx.sv
// -----------------------------------------------------------------------------
// a0_uart_tx
//
// Watches the core's 8-bit debug byte (low byte of a0). Each change of that
// byte is queued in a small FIFO. Queued bytes are sent as 8N1 UART frames so
// program results can be read off-chip. Nothing is handed back to the core:
// if the FIFO is full when a change arrives, the byte is dropped and a sticky
// overflow flag is set.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         asynchronous reset, active low
//   data_i        debug byte from the core
//   en_i          capture enable; when low, data_i is ignored
//   tx_o          UART serial line, idle high
//   busy_o        high while a frame is on the line (start .. last stop cycle)
//   fifo_count_o  current FIFO occupancy
//   overflow_o    sticky: a change was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module a0_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          en_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] last_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  overflow_q, overflow_d;

    state_e                state_q;
    logic [BAUD_W-1:0]     baud_q;
    logic [BIT_W-1:0]      bit_idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  tx_q;
    logic                  busy_q;

    // -------------------------------------------------------------------------
    // Change detect and FIFO control
    // -------------------------------------------------------------------------
    logic change;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic baud_wrap;

    assign change     = en_i && (data_i != last_q);
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO is
    // still accepted when the FSM is taking the head byte.
    assign push       = change && (!fifo_full || pop);
    assign baud_wrap  = (baud_q == BAUD_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (change && !push) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_i) begin
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (en_i) last_q <= data_i;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= data_i;
    end

    // -------------------------------------------------------------------------
    // Frame FSM with registered line and busy outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q <= S_START;
                        shift_q <= fifo_mem[rd_ptr_q];
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (baud_wrap) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        if (bit_idx_q == BIT_LAST) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            // Line takes the next bit while the register shifts.
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (baud_wrap) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign fifo_count_o = count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_a0_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_a0_uart_tx
//
// Directed bench for a0_uart_tx. Two instances share the stimulus: one with
// 4 clocks per bit (frame-level bit checks) and one with 16 clocks per bit
// (FIFO fill / overflow / reset scenarios). A small UART receiver per instance
// collects transmitted bytes for in-order comparison.
// -----------------------------------------------------------------------------
module tb_a0_uart_tx;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       en_i = 1'b1;

    logic       tx4, busy4, ovf4;
    logic [2:0] cnt4;
    logic       tx16, busy16, ovf16;
    logic [2:0] cnt16;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rx4_q[$];
    logic [7:0] rx16_q[$];

    logic       frame_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_ovf  [5]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [7:0] exp_full [6]  = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};

    always #5 clk_i = ~clk_i;

    a0_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DATA_WIDTH(8)) u_dut4 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .en_i         (en_i),
        .tx_o         (tx4),
        .busy_o       (busy4),
        .fifo_count_o (cnt4),
        .overflow_o   (ovf4)
    );

    a0_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4), .DATA_WIDTH(8)) u_dut16 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .en_i         (en_i),
        .tx_o         (tx16),
        .busy_o       (busy16),
        .fifo_count_o (cnt16),
        .overflow_o   (ovf16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i  = 1'b0;
        data_i = 8'h00;
        en_i   = 1'b1;
        repeat (3) tick();
        rx4_q.delete();
        rx16_q.delete();
        rst_i = 1'b1;
    endtask

    // Mid-bit sampling receiver; abandons a frame if reset is asserted.
    task automatic rx_loop(input int n, input bit sel);
        logic [7:0] b;
        logic       line;
        bit         ok;
        int         k;
        forever begin
            @(negedge clk_i);
            line = sel ? tx16 : tx4;
            if (rst_i && line == 1'b0) begin
                ok = 1'b1;
                b  = '0;
                for (int j = 1; j <= 9 * n + n / 2 && ok; j++) begin
                    @(negedge clk_i);
                    line = sel ? tx16 : tx4;
                    if (!rst_i) begin
                        ok = 1'b0;
                    end else if (j >= n / 2 && (j - n / 2) % n == 0) begin
                        k = (j - n / 2) / n;
                        if (k == 0 && line != 1'b0) ok = 1'b0;
                        else if (k >= 1 && k <= 8) b[k-1] = line;
                        else if (k == 9) begin
                            check(sel ? "rx16_stop" : "rx4_stop", 32'(line), 1);
                            if (sel) rx16_q.push_back(b);
                            else     rx4_q.push_back(b);
                        end
                    end
                end
            end
        end
    endtask

    initial rx_loop(4, 1'b0);
    initial rx_loop(16, 1'b1);

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int starts;
        int busy_cycles;
        logic prev_busy;

        // ---------------- Reset idle ----------------
        repeat (3) tick();
        check("rst_tx",   32'(tx4),   1);
        check("rst_busy", 32'(busy4), 0);
        check("rst_cnt",  32'(cnt4),  0);
        check("rst_ovf",  32'(ovf16), 0);
        data_i = 8'h00;
        en_i   = 1'b1;
        rst_i  = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            check("idle_tx4",   32'(tx4),   1);
            check("idle_busy4", 32'(busy4), 0);
            check("idle_cnt4",  32'(cnt4),  0);
            check("idle_tx16",  32'(tx16),  1);
        end

        // ---------------- Single byte, 4 clocks/bit ----------------
        data_i = 8'hA5;
        tick();                                   // edge k
        check("sb_cnt_k",  32'(cnt4),  1);
        check("sb_tx_k",   32'(tx4),   1);
        check("sb_busy_k", 32'(busy4), 0);
        tick();                                   // edge k+1: pop, start bit
        check("sb_tx_k1",   32'(tx4),   0);
        check("sb_busy_k1", 32'(busy4), 1);
        check("sb_cnt_k1",  32'(cnt4),  0);
        for (int j = 0; j <= 40; j++) begin
            if (j >= 2 && (j - 2) % 4 == 0 && (j - 2) / 4 < 10)
                check($sformatf("sb_bit%0d", (j - 2) / 4), 32'(tx4), 32'(frame_a5[(j - 2) / 4]));
            if (j == 39) check("sb_busy_last", 32'(busy4), 1);
            if (j == 40) check("sb_busy_end",  32'(busy4), 0);
            if (j < 40) tick();
        end
        check("sb_rx_n", 32'(rx4_q.size()), 1);
        if (rx4_q.size() > 0) check("sb_rx_val", 32'(rx4_q[0]), 32'hA5);

        // ---------------- Enable gating and no-change suppression ----------------
        do_reset();
        en_i   = 1'b0;
        data_i = 8'h3C;
        for (int c = 0; c < 20; c++) tick();
        check("en_lo_cnt",  32'(cnt4),  0);
        check("en_lo_busy", 32'(busy4), 0);
        en_i = 1'b1;
        tick();
        check("en_hi_cnt", 32'(cnt4), 1);
        starts    = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (busy4 && !prev_busy) starts++;
            prev_busy = busy4;
        end
        check("nc_frames", 32'(starts), 1);
        check("nc_rx_n",   32'(rx4_q.size()), 1);
        if (rx4_q.size() > 0) check("nc_rx_val", 32'(rx4_q[0]), 32'h3C);

        // ---------------- Overflow, 16 clocks/bit ----------------
        do_reset();
        for (int v = 1; v <= 6; v++) begin
            data_i = 8'(v);
            tick();
        end
        check("ov_cnt",  32'(cnt16), 4);
        check("ov_flag", 32'(ovf16), 1);
        for (int c = 0; c < 1200 && !(rx16_q.size() == 5 && !busy16 && cnt16 == 0); c++) tick();
        check("ov_rx_n", 32'(rx16_q.size()), 5);
        for (int i = 0; i < 5 && i < rx16_q.size(); i++)
            check($sformatf("ov_rx%0d", i), 32'(rx16_q[i]), 32'(exp_ovf[i]));
        repeat (50) tick();
        check("ov_sticky", 32'(ovf16), 1);
        check("ov_rx_end", 32'(rx16_q.size()), 5);

        // ---------------- Push and pop on the same edge while full ----------------
        do_reset();
        for (int v = 8'h11; v <= 8'h15; v++) begin
            data_i = 8'(v);
            tick();
        end
        check("pf_cnt_full", 32'(cnt16), 4);
        check("pf_busy",     32'(busy16), 1);
        for (int c = 0; c < 400 && busy16; c++) tick();
        check("pf_idle", 32'(busy16), 0);
        data_i = 8'h16;                           // sampled on the pop edge
        tick();
        check("pf_cnt_same", 32'(cnt16), 4);
        check("pf_ovf",      32'(ovf16), 0);
        check("pf_restart",  32'(busy16), 1);
        for (int c = 0; c < 1400 && !(rx16_q.size() == 6 && !busy16 && cnt16 == 0); c++) tick();
        check("pf_rx_n", 32'(rx16_q.size()), 6);
        for (int i = 0; i < 6 && i < rx16_q.size(); i++)
            check($sformatf("pf_rx%0d", i), 32'(rx16_q[i]), 32'(exp_full[i]));
        check("pf_ovf_end", 32'(ovf16), 0);

        // ---------------- Async reset mid-frame ----------------
        do_reset();
        data_i = 8'hC3;                           // bit 3 is 0
        tick();
        tick();                                   // start bit on the line
        repeat (70) tick();                       // inside data bit 3
        check("mr_pre_tx",   32'(tx16),   0);
        check("mr_pre_busy", 32'(busy16), 1);
        #2;
        rst_i  = 1'b0;
        data_i = 8'h00;
        #1;
        check("mr_tx",   32'(tx16),   1);
        check("mr_busy", 32'(busy16), 0);
        check("mr_cnt",  32'(cnt16),  0);
        @(negedge clk_i);
        rx4_q.delete();
        rx16_q.delete();
        tick();
        rst_i = 1'b1;
        busy_cycles = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (busy16 || !tx16) busy_cycles++;
        end
        check("mr_quiet", 32'(busy_cycles), 0);
        check("mr_rx_none", 32'(rx16_q.size()), 0);
        data_i = 8'h3E;
        for (int c = 0; c < 300 && !(rx16_q.size() == 1 && !busy16); c++) tick();
        check("mr_rx_n", 32'(rx16_q.size()), 1);
        if (rx16_q.size() > 0) check("mr_rx_val", 32'(rx16_q[0]), 32'h3E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
